// File: rtl/clk_en_monitor_if.sv
// Strobe/status bundle between the strobe generator side (master) and the
// clk_en_monitor checker (slave).
interface clk_en_monitor_if #(
  parameter int ERR_W = 8,
  parameter int IDX_W = 2
);
  logic             sam_clk_en;
  logic             sym_clk_en;
  logic             sys_clk2_en;
  logic             locked;
  logic [IDX_W-1:0] sam_idx;
  logic             sam_err;
  logic             sym_err;
  logic             coin_err;
  logic             clk2_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output sam_clk_en, sym_clk_en, sys_clk2_en,
    input  locked, sam_idx, sam_err, sym_err, coin_err, clk2_err, err_count
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, sys_clk2_en,
    output locked, sam_idx, sam_err, sym_err, coin_err, clk2_err, err_count
  );
endinterface

// File: rtl/clk_en_monitor.sv
// clk_en_monitor: receive-side checker for the sam/sym/clk2 strobe set.
// Measures sam strobe spacing, sam/sym coincidence and samples per symbol,
// recovers the sample index, and declares lock after LOCK_SYMS clean symbols.
// Every violation is a registered one-cycle pulse plus a saturating count.
// Optional feature macro: CLK2_CHECK_EN (toggle check of sys_clk2_en).
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_SEARCH  | idle, waiting for a sym strobe; error reporting suppressed
//  ST_ACQUIRE | checks armed, counting clean symbols toward lock
//  ST_LOCKED  | stream clean; any error drops back to ST_SEARCH
module clk_en_monitor #(
  parameter int SAM_PERIOD = 4,
  parameter int SPS        = 4,
  parameter int LOCK_SYMS  = 2,
  parameter int GAP_W      = 5,
  parameter int ERR_W      = 8
) (
  input logic              clk,
  input logic              reset,
  clk_en_monitor_if.slave  bus
);

  localparam int IDX_W  = (SPS > 1) ? $clog2(SPS) : 1;
  // sam_cnt must be able to exceed SPS so an over-long symbol is caught
  localparam int CNT_W  = $clog2(SPS + 2);
  localparam int GOOD_W = $clog2(LOCK_SYMS + 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   sam_cnt_q, sam_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               locked_q;
  logic [IDX_W-1:0]   sam_idx_q;
  logic               sam_err_q, sym_err_q, coin_err_q, clk2_err_q;
  logic               sam_err_d, sym_err_d, coin_err_d, clk2_err_d;
  logic               armed, early, miss, any_err;

`ifdef CLK2_CHECK_EN
  logic               clk2_prev_q;
`else
  logic               unused_clk2;
  assign unused_clk2 = bus.sys_clk2_en;
`endif

  // Error detection and next-state decode for counters and FSM
  always_comb begin
    armed = (state_q != ST_SEARCH);
    early = bus.sam_clk_en && (gap_q < GAP_W'(SAM_PERIOD));
    // gap passes SAM_PERIOD only once, so a miss is reported once and the
    // late strobe that follows (gap > SAM_PERIOD) is not flagged
    miss  = !bus.sam_clk_en && (gap_q == GAP_W'(SAM_PERIOD));

    sam_err_d  = armed && (early || miss);
    sym_err_d  = armed && bus.sym_clk_en && (sam_cnt_q != CNT_W'(SPS));
    coin_err_d = armed && bus.sym_clk_en && !bus.sam_clk_en;
`ifdef CLK2_CHECK_EN
    clk2_err_d = armed && (bus.sys_clk2_en == clk2_prev_q);
`else
    clk2_err_d = 1'b0;
`endif
    any_err = sam_err_d || sym_err_d || coin_err_d || clk2_err_d;

    gap_d = gap_q;
    if (bus.sam_clk_en) begin
      gap_d = GAP_W'(1);
    end else if (gap_q != {GAP_W{1'b1}}) begin
      gap_d = gap_q + GAP_W'(1);
    end

    sam_cnt_d = sam_cnt_q;
    idx_d     = idx_q;
    if (bus.sym_clk_en) begin
      sam_cnt_d = CNT_W'(1);
      idx_d     = '0;
    end else if (bus.sam_clk_en) begin
      if (sam_cnt_q != {CNT_W{1'b1}}) begin
        sam_cnt_d = sam_cnt_q + CNT_W'(1);
      end
      idx_d = (idx_q == IDX_W'(SPS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_SEARCH: begin
        if (bus.sym_clk_en) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end else if (bus.sym_clk_en) begin
          good_d = good_q + GOOD_W'(1);
          if (good_q == GOOD_W'(LOCK_SYMS - 1)) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    err_count_d = err_count_q;
    if (any_err && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      gap_q       <= '0;
      sam_cnt_q   <= '0;
      idx_q       <= '0;
      good_q      <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      sam_idx_q   <= '0;
      sam_err_q   <= 1'b0;
      sym_err_q   <= 1'b0;
      coin_err_q  <= 1'b0;
      clk2_err_q  <= 1'b0;
`ifdef CLK2_CHECK_EN
      clk2_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      sam_cnt_q   <= sam_cnt_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      err_count_q <= err_count_d;
      locked_q    <= (state_d == ST_LOCKED);
      sam_idx_q   <= (state_d == ST_LOCKED) ? idx_d : '0;
      sam_err_q   <= sam_err_d;
      sym_err_q   <= sym_err_d;
      coin_err_q  <= coin_err_d;
      clk2_err_q  <= clk2_err_d;
`ifdef CLK2_CHECK_EN
      clk2_prev_q <= bus.sys_clk2_en;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.sam_idx   = sam_idx_q;
  assign bus.sam_err   = sam_err_q;
  assign bus.sym_err   = sym_err_q;
  assign bus.coin_err  = coin_err_q;
  assign bus.clk2_err  = clk2_err_q;
  assign bus.err_count = err_count_q;

endmodule
